// File: rtl/cam_pkg.sv
// Shared defaults and helpers for the CAM read front-end.
package cam_pkg;

  localparam int CAM_DATA_WIDTH = 32;
  localparam int CAM_ADDR_WIDTH = 5;
  localparam int CAM_DEPTH      = 32;
  localparam int CAM_NUM_PORTS  = 2;

  // A read lane holds at most one response: either nothing or one payload.
  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  // Width needed to count from 0 up to and including depth.
  function automatic int cam_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cam_read_port_if.sv
// Request/response handshake bundle for all read lanes of the CAM read port.
// Lane p occupies bit p of the scalar vectors and the p-th field of the packed buses.
interface cam_read_port_if
  import cam_pkg::*;
#(
  parameter int NUM_PORTS  = CAM_NUM_PORTS,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = CAM_DATA_WIDTH
) ();

  logic [NUM_PORTS-1:0]            req_valid_i;
  logic [NUM_PORTS-1:0]            req_ready_o;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_index_i;
  logic [NUM_PORTS-1:0]            rsp_valid_o;
  logic [NUM_PORTS-1:0]            rsp_ready_i;
  logic [NUM_PORTS-1:0]            rsp_hit_o;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] rsp_index_o;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data_o;

  modport slave (
    input  req_valid_i, req_index_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_index_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o
  );

endinterface

// File: rtl/cam_read_lane.sv
// One read lane: selects an entry from the flattened CAM array and holds it in a
// single response register with valid/ready handshaking on both sides.
module cam_read_lane
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DEPTH      = CAM_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [DEPTH*DATA_WIDTH-1:0] all_data_i,
  input  logic [DEPTH-1:0]            entry_valid_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ADDR_WIDTH-1:0]       req_index_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic                        rsp_hit_o,
  output logic [ADDR_WIDTH-1:0]       rsp_index_o,
  output logic [DATA_WIDTH-1:0]       rsp_data_o,
  output logic                        oor_o
);

  lane_state_e           r_state;
  logic                  r_hit;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_data;

  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_hit;
  logic                  w_inRange;
  logic                  w_accept;

  // AND-OR entry select; an index past the last entry matches nothing and yields zeros.
  always_comb begin
    w_data    = '0;
    w_hit     = 1'b0;
    w_inRange = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (req_index_i == ADDR_WIDTH'(k)) begin
        w_data    = all_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_hit     = entry_valid_i[k];
        w_inRange = 1'b1;
      end
    end
  end

  assign req_ready_o = (r_state == LANE_EMPTY) || rsp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign oor_o       = w_accept && !w_inRange;

  // Response register: a new accept always loads, otherwise a consumed response empties the lane.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= LANE_EMPTY;
      r_hit   <= 1'b0;
      r_index <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        LANE_EMPTY: begin
          if (w_accept) begin
            r_state <= LANE_FULL;
            r_hit   <= w_hit;
            r_index <= req_index_i;
            r_data  <= w_data;
          end
        end
        LANE_FULL: begin
          if (w_accept) begin
            r_hit   <= w_hit;
            r_index <= req_index_i;
            r_data  <= w_data;
          end else if (rsp_ready_i) begin
            r_state <= LANE_EMPTY;
          end
        end
        default: r_state <= LANE_EMPTY;
      endcase
    end
  end

  assign rsp_valid_o = (r_state == LANE_FULL);
  assign rsp_hit_o   = r_hit;
  assign rsp_index_o = r_index;
  assign rsp_data_o  = r_data;

endmodule

// File: rtl/cam_read_port.sv
// Multi-lane registered read front-end for the CAM array, plus registered
// any-valid, valid-entry count and a sticky out-of-range error flag.
module cam_read_port
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DEPTH      = CAM_DEPTH,
  parameter int NUM_PORTS  = CAM_NUM_PORTS
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [DEPTH*DATA_WIDTH-1:0]   all_data_i,
  input  logic [DEPTH-1:0]              entry_valid_i,
  cam_read_port_if.slave                bus,
  output logic                          any_valid_o,
  output logic [cam_cnt_w(DEPTH)-1:0]   valid_count_o,
  output logic                          oor_err_o,
  input  logic                          clr_err_i
);

  localparam int CNT_W = cam_cnt_w(DEPTH);

  logic [NUM_PORTS-1:0]            w_reqReady;
  logic [NUM_PORTS-1:0]            w_rspValid;
  logic [NUM_PORTS-1:0]            w_rspHit;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] w_rspIndex;
  logic [NUM_PORTS*DATA_WIDTH-1:0] w_rspData;
  logic [NUM_PORTS-1:0]            w_oor;
  logic [CNT_W-1:0]                w_count;

  logic                            r_anyValid;
  logic [CNT_W-1:0]                r_count;
  logic                            r_oorErr;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    cam_read_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_lane (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .all_data_i    (all_data_i),
      .entry_valid_i (entry_valid_i),
      .req_valid_i   (bus.req_valid_i[p]),
      .req_ready_o   (w_reqReady[p]),
      .req_index_i   (bus.req_index_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .rsp_valid_o   (w_rspValid[p]),
      .rsp_ready_i   (bus.rsp_ready_i[p]),
      .rsp_hit_o     (w_rspHit[p]),
      .rsp_index_o   (w_rspIndex[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .rsp_data_o    (w_rspData[p*DATA_WIDTH +: DATA_WIDTH]),
      .oor_o         (w_oor[p])
    );
  end

  assign bus.req_ready_o = w_reqReady;
  assign bus.rsp_valid_o = w_rspValid;
  assign bus.rsp_hit_o   = w_rspHit;
  assign bus.rsp_index_o = w_rspIndex;
  assign bus.rsp_data_o  = w_rspData;

  // Population count of valid entries, wide enough that all-valid does not wrap.
  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + CNT_W'(entry_valid_i[k]);
    end
  end

  // Occupancy summary is re-sampled every cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_anyValid <= 1'b0;
      r_count    <= '0;
    end else begin
      r_anyValid <= |entry_valid_i;
      r_count    <= w_count;
    end
  end

  // Sticky error: a fresh out-of-range accept takes priority over a clear in the same cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_oorErr <= 1'b0;
    end else if (|w_oor) begin
      r_oorErr <= 1'b1;
    end else if (clr_err_i) begin
      r_oorErr <= 1'b0;
    end
  end

  assign any_valid_o   = r_anyValid;
  assign valid_count_o = r_count;
  assign oor_err_o     = r_oorErr;

endmodule

// File: tb/tb_cam_read_port.sv
// Bench for cam_read_port: two instances (DEPTH 32 and DEPTH 20) share one stimulus
// stream; a per-lane response queue model predicts every registered output.
module tb_cam_read_port;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        hit;
  } rsp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       mem [32];
  logic [32*32-1:0]  allData;
  logic [31:0]       entryValid;
  logic              clrErr;
  logic [1:0]        reqValid;
  logic [4:0]        reqIndex [2];
  logic [1:0]        rspReady;

  logic              anyValid32, anyValid20, err32, err20;
  logic [5:0]        count32;
  logic [4:0]        count20;

  rsp_t              expQ [4][$];
  logic              expAny [2];
  int                expCount [2];
  logic              expErr [2];

  int                nCompared = 0;
  int                nMismatch = 0;

  cam_read_port_if #(.NUM_PORTS(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus32 ();
  cam_read_port_if #(.NUM_PORTS(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus20 ();

  cam_read_port #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .NUM_PORTS(2)) dut32 (
    .clk_i(clk), .reset_i(reset), .all_data_i(allData), .entry_valid_i(entryValid),
    .bus(bus32), .any_valid_o(anyValid32), .valid_count_o(count32),
    .oor_err_o(err32), .clr_err_i(clrErr)
  );

  cam_read_port #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(20), .NUM_PORTS(2)) dut20 (
    .clk_i(clk), .reset_i(reset), .all_data_i(allData[20*32-1:0]),
    .entry_valid_i(entryValid[19:0]), .bus(bus20), .any_valid_o(anyValid20),
    .valid_count_o(count20), .oor_err_o(err20), .clr_err_i(clrErr)
  );

  always #5 clk = ~clk;

  // Flatten the entry model onto the array bus.
  always_comb begin
    for (int k = 0; k < 32; k++) allData[k*32 +: 32] = mem[k];
  end

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveBus();
    bus32.req_valid_i = reqValid;
    bus20.req_valid_i = reqValid;
    bus32.req_index_i = {reqIndex[1], reqIndex[0]};
    bus20.req_index_i = {reqIndex[1], reqIndex[0]};
    bus32.rsp_ready_i = rspReady;
    bus20.rsp_ready_i = rspReady;
  endtask

  task automatic clearModel();
    for (int q = 0; q < 4; q++) expQ[q].delete();
    for (int d = 0; d < 2; d++) begin
      expAny[d]   = 1'b0;
      expCount[d] = 0;
      expErr[d]   = 1'b0;
    end
  endtask

  task automatic checkDut(input int d, input logic [1:0] rdy, input logic [1:0] vld,
                          input logic [1:0] hit, input logic [9:0] idx, input logic [63:0] data,
                          input logic anyV, input int cnt, input logic err);
    int depth;
    depth = (d == 0) ? 32 : 20;
    for (int p = 0; p < 2; p++) begin
      int q;
      q = d*2 + p;
      expectEq($sformatf("d%0d.l%0d.ready", depth, p), 64'(rdy[p]),
               64'(expQ[q].size() == 0 || rspReady[p]));
      expectEq($sformatf("d%0d.l%0d.valid", depth, p), 64'(vld[p]), 64'(expQ[q].size() != 0));
      if (expQ[q].size() != 0) begin
        expectEq($sformatf("d%0d.l%0d.hit", depth, p), 64'(hit[p]), 64'(expQ[q][0].hit));
        expectEq($sformatf("d%0d.l%0d.index", depth, p), 64'(idx[p*5 +: 5]), 64'(expQ[q][0].idx));
        expectEq($sformatf("d%0d.l%0d.data", depth, p), 64'(data[p*32 +: 32]), 64'(expQ[q][0].data));
      end
    end
    expectEq($sformatf("d%0d.any", depth), 64'(anyV), 64'(expAny[d]));
    expectEq($sformatf("d%0d.count", depth), 64'(cnt), 64'(expCount[d]));
    expectEq($sformatf("d%0d.err", depth), 64'(err), 64'(expErr[d]));
  endtask

  task automatic checkOutput();
    checkDut(0, bus32.req_ready_o, bus32.rsp_valid_o, bus32.rsp_hit_o, bus32.rsp_index_o,
             bus32.rsp_data_o, anyValid32, int'(count32), err32);
    checkDut(1, bus20.req_ready_o, bus20.rsp_valid_o, bus20.rsp_hit_o, bus20.rsp_index_o,
             bus20.rsp_data_o, anyValid20, int'(count20), err20);
  endtask

  // What the next rising edge does, stated as queue operations on expected responses.
  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      int   depth;
      int   cnt;
      logic oorSeen;
      depth   = (d == 0) ? 32 : 20;
      oorSeen = 1'b0;
      for (int p = 0; p < 2; p++) begin
        int   q;
        logic ready;
        rsp_t r;
        q     = d*2 + p;
        ready = (expQ[q].size() == 0) || rspReady[p];
        if (expQ[q].size() != 0 && rspReady[p]) void'(expQ[q].pop_front());
        if (reqValid[p] && ready) begin
          r.idx  = reqIndex[p];
          r.data = (int'(reqIndex[p]) < depth) ? mem[reqIndex[p]] : 32'd0;
          r.hit  = (int'(reqIndex[p]) < depth) ? entryValid[reqIndex[p]] : 1'b0;
          if (int'(reqIndex[p]) >= depth) oorSeen = 1'b1;
          expQ[q].push_back(r);
        end
      end
      cnt = 0;
      for (int k = 0; k < depth; k++) cnt += int'(entryValid[k]);
      expCount[d] = cnt;
      expAny[d]   = (cnt != 0);
      if (oorSeen) expErr[d] = 1'b1;
      else if (clrErr) expErr[d] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rv, input logic [4:0] i0, input logic [4:0] i1,
                               input logic [1:0] rr, input logic clr);
    reqValid    = rv;
    reqIndex[0] = i0;
    reqIndex[1] = i1;
    rspReady    = rr;
    clrErr      = clr;
    driveBus();
    #1;
    checkOutput();
    modelEdge();
    @(negedge clk);
  endtask

  task automatic checkReset();
    expectEq("rst.d32.valid", 64'(bus32.rsp_valid_o), 64'd0);
    expectEq("rst.d20.valid", 64'(bus20.rsp_valid_o), 64'd0);
    expectEq("rst.d32.ready", 64'(bus32.req_ready_o), 64'h3);
    expectEq("rst.d20.ready", 64'(bus20.req_ready_o), 64'h3);
    expectEq("rst.d32.hit", 64'(bus32.rsp_hit_o), 64'd0);
    expectEq("rst.d32.index", 64'(bus32.rsp_index_o), 64'd0);
    expectEq("rst.d32.data", 64'(bus32.rsp_data_o), 64'd0);
    expectEq("rst.d20.data", 64'(bus20.rsp_data_o), 64'd0);
    expectEq("rst.d32.any", 64'(anyValid32), 64'd0);
    expectEq("rst.d32.count", 64'(count32), 64'd0);
    expectEq("rst.d32.err", 64'(err32), 64'd0);
    expectEq("rst.d20.err", 64'(err20), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = 32'd0;
    entryValid  = 32'd0;
    clrErr      = 1'b0;
    reqValid    = 2'b11;
    reqIndex[0] = 5'd0;
    reqIndex[1] = 5'd0;
    rspReady    = 2'b00;
    driveBus();
    clearModel();
    #1 reset = 1'b1;
    #1 checkReset();
    @(negedge clk);
    reset = 1'b0;

    // Two populated entries; lane 0 reads a valid entry, lane 1 an invalid one.
    mem[0]     = 32'd48371832;
    mem[1]     = 32'd49385029;
    entryValid = 32'h0000_0003;
    applyStimulus(2'b11, 5'd1, 5'd2, 2'b11, 1'b0);
    expectEq("first.valid", 64'(bus32.rsp_valid_o), 64'h3);
    expectEq("first.data", 64'(bus32.rsp_data_o[31:0]), 64'd49385029);
    expectEq("first.hit0", 64'(bus32.rsp_hit_o[0]), 64'd1);
    expectEq("first.hit1", 64'(bus32.rsp_hit_o[1]), 64'd0);

    // Backpressure on both lanes while the array contents change underneath.
    for (int c = 0; c < 4; c++) begin
      mem[1] = 32'hDEAD_BEEF + 32'(c);
      applyStimulus(2'b01, 5'd3, 5'd0, 2'b00, 1'b0);
      expectEq("hold.ready0", 64'(bus32.req_ready_o[0]), 64'd0);
      expectEq("hold.data", 64'(bus32.rsp_data_o[31:0]), 64'd49385029);
    end
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);

    // Back-to-back requests, one response per cycle in order.
    for (int k = 0; k < 4; k++) mem[k] = $urandom;
    entryValid = $urandom;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 5'(i), 5'd0, 2'b11, 1'b0);
      expectEq("b2b.valid", 64'(bus32.rsp_valid_o[0]), 64'd1);
      expectEq("b2b.index", 64'(bus32.rsp_index_o[4:0]), 64'(i));
    end
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);

    // Out-of-range index on the 20-entry instance, clear, then set-beats-clear.
    applyStimulus(2'b10, 5'd0, 5'd25, 2'b11, 1'b0);
    expectEq("oor.hit", 64'(bus20.rsp_hit_o[1]), 64'd0);
    expectEq("oor.data", 64'(bus20.rsp_data_o[63:32]), 64'd0);
    expectEq("oor.err20", 64'(err20), 64'd1);
    expectEq("oor.err32", 64'(err32), 64'd0);
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b1);
    expectEq("oor.cleared", 64'(err20), 64'd0);
    applyStimulus(2'b10, 5'd0, 5'd30, 2'b11, 1'b1);
    expectEq("oor.setwins", 64'(err20), 64'd1);
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b1);

    // Empty array, then completely full.
    entryValid = 32'h0000_0000;
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);
    expectEq("pop.zero.any", 64'(anyValid32), 64'd0);
    expectEq("pop.zero.count", 64'(count32), 64'd0);
    entryValid = 32'hFFFF_FFFF;
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);
    expectEq("pop.full.any", 64'(anyValid32), 64'd1);
    expectEq("pop.full.count32", 64'(count32), 64'd32);
    expectEq("pop.full.count20", 64'(count20), 64'd20);

    // Random traffic against the queue model.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 31)] = $urandom;
      if ($urandom_range(0, 7) == 0) entryValid = $urandom;
      applyStimulus(2'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
                    ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset while both lanes hold a response.
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);
    applyStimulus(2'b11, 5'd4, 5'd5, 2'b00, 1'b0);
    expectEq("midrst.before", 64'(bus32.rsp_valid_o), 64'h3);
    reset = 1'b1;
    #1;
    checkReset();
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);
    applyStimulus(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
